// File: rtl/bus_arbiter_pkg.sv
// Shared types for the round-robin bus arbiter: FSM state encoding and the
// wide owner index used to remember the last granted requester.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      OWN     = 2'd2,
      RELEASE = 2'd3
   } state_e;

   // Wide enough for the largest supported requester count (16).
   localparam int OWNER_MAX_W = 4;
   typedef logic [OWNER_MAX_W-1:0] owner_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward
// from last+1, wrapping to index 0.
module rr_pick
   import bus_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  owner_t           last,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   logic             hi_found;
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] lo_idx;

   // Scanning downward leaves the lowest qualifying index in each candidate.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_idx = IDX_W'(j);
            if (j > int'(last)) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(j);
            end
         end
      end
      valid = |req;
      index = hi_found ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave request/grant port among N_REQ masters,
// with a per-grant hold limit. All outputs come straight from flops.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          m_req,
   input  logic [N_REQ*DATA_W-1:0]   m_data,
   output logic [N_REQ-1:0]          m_gnt,
   output logic                      s_req,
   output logic [DATA_W-1:0]         s_data,
   input  logic                      s_gnt,
   output logic [$clog2(N_REQ)-1:0]  owner,
   output logic                      busy
);

   localparam int OW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_HOLD);

   state_e            state_q, state_d;
   logic [OW-1:0]     owner_q, owner_d;
   owner_t            last_owner_q, last_owner_d;
   logic [CW-1:0]     hold_q, hold_d;
   logic [N_REQ-1:0]  m_gnt_q, m_gnt_d;
   logic              s_req_q, s_req_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;
   logic [OW-1:0]     owner_out_q, owner_out_d;
   logic              busy_q, busy_d;

   logic              pick_valid;
   logic [OW-1:0]     pick_idx;
   logic [DATA_W-1:0] sel_data;
   logic              hold_cap;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(OW)) u_pick (
      .req   (m_req),
      .last  (last_owner_q),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_comb begin
      sel_data = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (owner_q == OW'(j)) sel_data = m_data[j*DATA_W +: DATA_W];
      end
   end

   assign hold_cap = (hold_q == CW'(MAX_HOLD - 1));

   // Handshake: s_req stays high from REQ through OWN; the slave asserts s_gnt
   // to hand over the bus and may drop it at any time to preempt the owner.
   // An aborted request (owner drops m_req in REQ) leaves last_owner alone.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      hold_d       = hold_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = REQ;
               owner_d = pick_idx;
            end
         end
         REQ: begin
            if (!m_req[owner_q]) begin
               state_d = IDLE;
            end else if (s_gnt) begin
               state_d      = OWN;
               last_owner_d = owner_t'(owner_q);
               hold_d       = '0;
            end
         end
         OWN: begin
            if (!m_req[owner_q] || !s_gnt || hold_cap) begin
               state_d = RELEASE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_gnt_d     = '0;
      s_req_d     = 1'b0;
      s_data_d    = '0;
      owner_out_d = '0;
      busy_d      = (state_q != IDLE);
      if (state_q == REQ || state_q == OWN) begin
         s_req_d  = 1'b1;
         s_data_d = sel_data;
      end
      if (state_q != IDLE) owner_out_d = owner_q;
      if (state_q == OWN) m_gnt_d[owner_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= owner_t'(N_REQ - 1);
         hold_q       <= '0;
         m_gnt_q      <= '0;
         s_req_q      <= 1'b0;
         s_data_q     <= '0;
         owner_out_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         hold_q       <= hold_d;
         m_gnt_q      <= m_gnt_d;
         s_req_q      <= s_req_d;
         s_data_q     <= s_data_d;
         owner_out_q  <= owner_out_d;
         busy_q       <= busy_d;
      end
   end

   assign m_gnt  = m_gnt_q;
   assign s_req  = s_req_q;
   assign s_data = s_data_q;
   assign owner  = owner_out_q;
   assign busy   = busy_q;

endmodule
